// File: rtl/beta_if_stage_pkg.sv
// Shared types for the IF-stage front end (prefetch buffer and fetch unit).
//   pb_state_t / PB_STATE_W : prefetch buffer FSM encoding and its width
//   pb_entry_t              : one buffered {pc, instr} pair
//   RV_NOP                  : canonical RISC-V NOP (addi x0, x0, 0)
package beta_if_stage_pkg;

    localparam int unsigned PB_STATE_W = 2;
    localparam int unsigned PB_ADDR_W  = 32;
    localparam int unsigned PB_DATA_W  = 32;

    typedef enum logic [PB_STATE_W-1:0] {
        PB_IDLE    = 2'd0,
        PB_WAIT    = 2'd1,
        PB_DISCARD = 2'd2
    } pb_state_t;

    typedef struct packed {
        logic [PB_ADDR_W-1:0] pc;
        logic [PB_DATA_W-1:0] instr;
    } pb_entry_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/beta_pb_fifo.sv
// Generic synchronous FIFO used by the prefetch buffer.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : drop all entries (wins over push/pop)
//   push_i/wdata_i : write one entry (ignored when full)
//   pop_i          : advance the head (ignored when empty)
//   rdata_o        : head entry
//   count_o        : occupancy, full_o / empty_o flags
module beta_pb_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    // Pointer/count update; Depth is a power of two so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PtrW'(1);
            if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
            count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the head is only consumed when count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer between the fetch unit and the IF stage.
// Owns the fetch PC, keeps at most one fetch outstanding, buffers returned
// {pc, instr} pairs in a FIFO and hands them out with valid/ready. A redirect
// flushes the FIFO and marks any in-flight response for discard.
// Optional build macro BETA_PB_BYPASS_EN: a response arriving into an empty
// FIFO is presented to the IF stage in the same cycle.
// Ports:
//   clk_i, rst_i                          : clock, synchronous active-high reset
//   pb_fetch_en_o, pb_fetch_addr_o        : fetch request to the fetch unit
//   pb_fu_new_instr_i, pb_fu_instr_i      : fetch unit response
//   pb_fu_ctrl_hazard_o                   : tells the fetch unit to NOP the response
//   pb_flush_i, pb_flush_addr_i           : redirect
//   pb_instr_valid_o/_o, pb_pc_o, _ready_i: IF stage handshake
//   pb_count_o, pb_empty_o, pb_full_o     : occupancy
module beta_prefetch_buffer
    import beta_if_stage_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          Depth     = 4,
    parameter logic [AddrWidth-1:0] BootAddr  = AddrWidth'(32'h0000_0000)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       pb_fetch_en_o,
    output logic [AddrWidth-1:0]       pb_fetch_addr_o,
    input  logic                       pb_fu_new_instr_i,
    input  logic [DataWidth-1:0]       pb_fu_instr_i,
    output logic                       pb_fu_ctrl_hazard_o,
    input  logic                       pb_flush_i,
    input  logic [AddrWidth-1:0]       pb_flush_addr_i,
    output logic                       pb_instr_valid_o,
    output logic [DataWidth-1:0]       pb_instr_o,
    output logic [AddrWidth-1:0]       pb_pc_o,
    input  logic                       pb_instr_ready_i,
    output logic [$clog2(Depth+1)-1:0] pb_count_o,
    output logic                       pb_empty_o,
    output logic                       pb_full_o
);

    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam int unsigned EntryW = AddrWidth + DataWidth;
    localparam int unsigned PcStep = DataWidth / 8;

    pb_state_t            state_q, state_d;
    logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
    logic [AddrWidth-1:0] req_pc_q, req_pc_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [EntryW-1:0]    fifo_wdata;
    logic [EntryW-1:0]    fifo_rdata;
    logic [CntW-1:0]      fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic                 fetch_en_c;
    logic                 resp_keep_c;
    logic                 head_valid_c;
    logic                 bypass_c;

    // Issue only when idle, room is guaranteed and no redirect is in progress.
    assign fetch_en_c   = (state_q == PB_IDLE) && (fifo_count < CntW'(Depth))
                          && !pb_flush_i && !rst_i;
    assign resp_keep_c  = (state_q == PB_WAIT) && pb_fu_new_instr_i && !pb_flush_i;
    assign head_valid_c = !fifo_empty && !pb_flush_i;

`ifdef BETA_PB_BYPASS_EN
    assign bypass_c = fifo_empty && resp_keep_c;
`else
    assign bypass_c = 1'b0;
`endif

    // Next-state, fetch PC and request PC; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (pb_flush_i) begin
            fetch_pc_d = pb_flush_addr_i;
            if (state_q != PB_IDLE) begin
                state_d = pb_fu_new_instr_i ? PB_IDLE : PB_DISCARD;
            end
        end else begin
            case (state_q)
                PB_IDLE: begin
                    if (fetch_en_c) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + AddrWidth'(PcStep);
                        state_d    = PB_WAIT;
                    end
                end
                PB_WAIT: begin
                    if (pb_fu_new_instr_i) state_d = PB_IDLE;
                end
                PB_DISCARD: begin
                    if (pb_fu_new_instr_i) state_d = PB_IDLE;
                end
                default: state_d = PB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PB_IDLE;
            fetch_pc_q <= BootAddr;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // A bypassed response that is accepted immediately never enters the FIFO.
    assign fifo_push  = resp_keep_c && !(bypass_c && pb_instr_ready_i);
    assign fifo_pop   = head_valid_c && pb_instr_ready_i;
    assign fifo_wdata = {req_pc_q, pb_fu_instr_i};

    beta_pb_fifo #(
        .Width (EntryW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (pb_flush_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pb_fetch_en_o       = fetch_en_c;
    assign pb_fetch_addr_o     = (state_q != PB_IDLE) ? req_pc_q : fetch_pc_q;
    assign pb_fu_ctrl_hazard_o = (state_q == PB_DISCARD) || pb_flush_i;

    // Head payload is forced to zero when nothing is presented.
    assign pb_instr_valid_o = head_valid_c || bypass_c;
    assign pb_instr_o = bypass_c     ? pb_fu_instr_i :
                        head_valid_c ? fifo_rdata[DataWidth-1:0] : '0;
    assign pb_pc_o    = bypass_c     ? req_pc_q :
                        head_valid_c ? fifo_rdata[EntryW-1:DataWidth] : '0;

    assign pb_count_o = fifo_count;
    assign pb_empty_o = fifo_empty;
    assign pb_full_o  = fifo_full;

endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Directed testbench for beta_prefetch_buffer (Depth=4, BootAddr=0).
module tb_beta_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic        new_instr;
    logic [31:0] fu_instr;
    logic        hazard;
    logic        flush;
    logic [31:0] flush_addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    beta_prefetch_buffer #(
        .DataWidth (32),
        .AddrWidth (32),
        .Depth     (4),
        .BootAddr  (32'h0000_0000)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .pb_fetch_en_o       (fetch_en),
        .pb_fetch_addr_o     (fetch_addr),
        .pb_fu_new_instr_i   (new_instr),
        .pb_fu_instr_i       (fu_instr),
        .pb_fu_ctrl_hazard_o (hazard),
        .pb_flush_i          (flush),
        .pb_flush_addr_i     (flush_addr),
        .pb_instr_valid_o    (valid),
        .pb_instr_o          (instr),
        .pb_pc_o             (pc),
        .pb_instr_ready_i    (ready),
        .pb_count_o          (count),
        .pb_empty_o          (empty),
        .pb_full_o           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    // A push can never land in a full FIFO because issue is blocked when full.
    always @(negedge clk) begin
        if (!rst && full && fetch_en) begin
            total++; bad++;
            $display("FAIL overflow_guard fetch_en=1 while full");
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; new_instr = 1'b0; flush = 1'b0; ready = 1'b0;
        fu_instr = '0; flush_addr = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; new_instr = 1'b0; flush = 1'b0; ready = 1'b0;
        fu_instr = '0; flush_addr = '0;
        @(negedge clk); @(negedge clk); #1;
        total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL rst_fetch_en got=%0b exp=0", fetch_en); end
        total++; if (fetch_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", fetch_addr); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", full); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid); end
        total++; if (instr !== 32'h0 || pc !== 32'h0) begin bad++; $display("FAIL rst_head got=%h/%h exp=0/0", pc, instr); end
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%0b exp=0", hazard); end
    endtask

    task automatic test_basic;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            new_instr = 1'b0; ready = (i > 0); #1;
            total++; if (fetch_en !== 1'b1 || fetch_addr !== 32'(4*i)) begin bad++; $display("FAIL basic_issue%0d got=%0b/%h exp=1/%h", i, fetch_en, fetch_addr, 32'(4*i)); end
            if (i > 0) begin
                total++; if (valid !== 1'b1 || pc !== 32'(4*(i-1)) || instr !== w(i-1)) begin bad++; $display("FAIL basic_head%0d got=%0b/%h/%h exp=1/%h/%h", i, valid, pc, instr, 32'(4*(i-1)), w(i-1)); end
            end
            @(negedge clk);
            new_instr = 1'b1; fu_instr = w(i); ready = 1'b0; #1;
            total++; if (fetch_en !== 1'b0 || fetch_addr !== 32'(4*i)) begin bad++; $display("FAIL basic_outstanding%0d got=%0b/%h exp=0/%h", i, fetch_en, fetch_addr, 32'(4*i)); end
            @(negedge clk);
        end
        new_instr = 1'b0; ready = 1'b1; #1;
        total++; if (valid !== 1'b1 || pc !== 32'h8 || instr !== w(2)) begin bad++; $display("FAIL basic_head_last got=%0b/%h/%h exp=1/8/%h", valid, pc, instr, w(2)); end
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            new_instr = 1'b0; #1;
            total++; if (fetch_en !== 1'b1 || fetch_addr !== 32'(4*i) || count !== 3'(i)) begin bad++; $display("FAIL full_issue%0d got=%0b/%h/%0d exp=1/%h/%0d", i, fetch_en, fetch_addr, count, 32'(4*i), i); end
            @(negedge clk);
            new_instr = 1'b1; fu_instr = w(10+i); #1;
            @(negedge clk);
        end
        new_instr = 1'b0; #1;
        total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL full_flags got=%0b/%0d exp=1/4", full, count); end
        total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL full_no_issue got=%0b exp=0", fetch_en); end
        total++; if (valid !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL full_head got=%0b/%h exp=1/0", valid, pc); end
        @(negedge clk);
        ready = 1'b1; #1;
        total++; if (fetch_en !== 1'b0 || instr !== w(10)) begin bad++; $display("FAIL full_pop_cycle got=%0b/%h exp=0/%h", fetch_en, instr, w(10)); end
        @(negedge clk);
        ready = 1'b0; #1;
        total++; if (count !== 3'd3 || full !== 1'b0) begin bad++; $display("FAIL full_after_pop got=%0d/%0b exp=3/0", count, full); end
        total++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h10) begin bad++; $display("FAIL full_resume got=%0b/%h exp=1/10", fetch_en, fetch_addr); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL full_head2 got=%h exp=4", pc); end
        @(negedge clk);
        new_instr = 1'b1; fu_instr = w(14); ready = 1'b1; #1;
        total++; if (fetch_en !== 1'b0 || fetch_addr !== 32'h10) begin bad++; $display("FAIL full_inflight got=%0b/%h exp=0/10", fetch_en, fetch_addr); end
        @(negedge clk);
        new_instr = 1'b0; ready = 1'b0; #1;
        total++; if (count !== 3'd3 || pc !== 32'h8) begin bad++; $display("FAIL full_push_pop got=%0d/%h exp=3/8", count, pc); end
        @(negedge clk);
    endtask

    task automatic test_flush;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            new_instr = 1'b0; #1;
            @(negedge clk);
            new_instr = 1'b1; fu_instr = w(20+i); #1;
            @(negedge clk);
        end
        new_instr = 1'b0; #1;
        total++; if (count !== 3'd2 || fetch_en !== 1'b1 || fetch_addr !== 32'h8) begin bad++; $display("FAIL flush_setup got=%0d/%0b/%h exp=2/1/8", count, fetch_en, fetch_addr); end
        @(negedge clk);
        flush = 1'b1; flush_addr = 32'h100; #1;
        total++; if (hazard !== 1'b1 || valid !== 1'b0 || fetch_en !== 1'b0) begin bad++; $display("FAIL flush_cycle got=%0b/%0b/%0b exp=1/0/0", hazard, valid, fetch_en); end
        @(negedge clk);
        flush = 1'b0; #1;
        total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL flush_cleared got=%0d/%0b exp=0/1", count, empty); end
        total++; if (hazard !== 1'b1 || fetch_en !== 1'b0 || fetch_addr !== 32'h8) begin bad++; $display("FAIL flush_discard got=%0b/%0b/%h exp=1/0/8", hazard, fetch_en, fetch_addr); end
        @(negedge clk);
        new_instr = 1'b1; fu_instr = 32'hDEAD_BEEF; #1;
        total++; if (hazard !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL flush_doomed got=%0b/%0b exp=1/0", hazard, valid); end
        @(negedge clk);
        new_instr = 1'b0; #1;
        total++; if (hazard !== 1'b0 || count !== 3'd0 || fetch_en !== 1'b1 || fetch_addr !== 32'h100) begin bad++; $display("FAIL flush_resume got=%0b/%0d/%0b/%h exp=0/0/1/100", hazard, count, fetch_en, fetch_addr); end
        @(negedge clk);
        new_instr = 1'b1; fu_instr = w(29); #1;
        @(negedge clk);
        new_instr = 1'b0; #1;
        total++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== w(29)) begin bad++; $display("FAIL flush_new_head got=%0b/%h/%h exp=1/100/%h", valid, pc, instr, w(29)); end
        @(negedge clk);
    endtask

    task automatic test_flush_collide;
        do_reset();
        new_instr = 1'b0; #1;
        @(negedge clk);
        new_instr = 1'b1; fu_instr = w(30); #1;
        @(negedge clk);
        new_instr = 1'b0; #1;
        total++; if (count !== 3'd1 || fetch_en !== 1'b1 || fetch_addr !== 32'h4) begin bad++; $display("FAIL collide_setup got=%0d/%0b/%h exp=1/1/4", count, fetch_en, fetch_addr); end
        @(negedge clk);
        new_instr = 1'b1; fu_instr = w(31); flush = 1'b1; flush_addr = 32'h200; ready = 1'b1; #1;
        total++; if (valid !== 1'b0 || hazard !== 1'b1) begin bad++; $display("FAIL collide_cycle got=%0b/%0b exp=0/1", valid, hazard); end
        @(negedge clk);
        new_instr = 1'b0; flush = 1'b0; ready = 1'b0; #1;
        total++; if (count !== 3'd0 || empty !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL collide_empty got=%0d/%0b/%0b exp=0/1/0", count, empty, valid); end
        total++; if (hazard !== 1'b0 || fetch_en !== 1'b1 || fetch_addr !== 32'h200) begin bad++; $display("FAIL collide_resume got=%0b/%0b/%h exp=0/1/200", hazard, fetch_en, fetch_addr); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            new_instr = 1'b0; ready = (i > 0); #1;
            total++; if (fetch_en !== 1'b1 || fetch_addr !== 32'(4*i)) begin bad++; $display("FAIL wrap_issue%0d got=%0b/%h exp=1/%h", i, fetch_en, fetch_addr, 32'(4*i)); end
            if (i > 0) begin
                total++; if (valid !== 1'b1 || pc !== 32'(4*(i-1)) || instr !== w(40+i-1)) begin bad++; $display("FAIL wrap_head%0d got=%0b/%h/%h exp=1/%h/%h", i, valid, pc, instr, 32'(4*(i-1)), w(40+i-1)); end
            end
            @(negedge clk);
            new_instr = 1'b1; fu_instr = w(40+i); ready = 1'b0; #1;
            total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=0", i, count); end
            @(negedge clk);
        end
        new_instr = 1'b0; ready = 1'b1; #1;
        total++; if (valid !== 1'b1 || pc !== 32'h24 || instr !== w(49)) begin bad++; $display("FAIL wrap_last got=%0b/%h/%h exp=1/24/%h", valid, pc, instr, w(49)); end
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_stale;
        do_reset();
        new_instr = 1'b0; #1;
        @(negedge clk);
        new_instr = 1'b1; fu_instr = w(50); #1;
        @(negedge clk);
        new_instr = 1'b0; #1;
        @(negedge clk);
        rst = 1'b1; #1;
        total++; if (fetch_addr !== 32'h4) begin bad++; $display("FAIL stale_before got=%h exp=4", fetch_addr); end
        @(negedge clk);
        rst = 1'b0; new_instr = 1'b1; fu_instr = w(51); #1;
        total++; if (valid !== 1'b0 || count !== 3'd0 || fetch_addr !== 32'h0) begin bad++; $display("FAIL stale_cycle got=%0b/%0d/%h exp=0/0/0", valid, count, fetch_addr); end
        @(negedge clk);
        new_instr = 1'b0; #1;
        total++; if (count !== 3'd0 || empty !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL stale_dropped got=%0d/%0b/%0b exp=0/1/0", count, empty, valid); end
        total++; if (fetch_en !== 1'b0 || fetch_addr !== 32'h0) begin bad++; $display("FAIL stale_addr got=%0b/%h exp=0/0", fetch_en, fetch_addr); end
        @(negedge clk);
    endtask

    task automatic test_latency;
        do_reset();
        ready = 1'b1; new_instr = 1'b0; #1;
        @(negedge clk);
        new_instr = 1'b1; fu_instr = w(60); #1;
`ifdef BETA_PB_BYPASS_EN
        total++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== w(60)) begin bad++; $display("FAIL bypass_same_cycle got=%0b/%h/%h exp=1/0/%h", valid, pc, instr, w(60)); end
`else
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_resp_cycle got=%0b exp=0", valid); end
`endif
        @(negedge clk);
        new_instr = 1'b0; #1;
`ifdef BETA_PB_BYPASS_EN
        total++; if (valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL bypass_consumed got=%0b/%0d exp=0/0", valid, count); end
`else
        total++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== w(60)) begin bad++; $display("FAIL latency_next got=%0b/%h/%h exp=1/0/%h", valid, pc, instr, w(60)); end
`endif
        total++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h4) begin bad++; $display("FAIL latency_next_issue got=%0b/%h exp=1/4", fetch_en, fetch_addr); end
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_flush_collide();
        test_wrap();
        test_stale();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
